// File: rtl/fetch_unit_pkg.sv
// Shared encodings for the instruction fetch stage: next-PC mux select codes,
// fetch FSM states and the default reset PC.
package fetch_unit_pkg;

  localparam logic [1:0]  PC_SEL_INC       = 2'b00;
  localparam logic [1:0]  PC_SEL_BR        = 2'b01;
  localparam logic [1:0]  PC_SEL_JMP       = 2'b10;
  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    FETCH    = 2'b00,
    DISCARD  = 2'b01,
    WAIT_DEC = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, sequences imem reads, hands words to decode.
// Optional build macro FETCH_PERF_EN adds the stall_count decode-stall counter.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 16,
  parameter int unsigned       INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               branch_taken,
  input  logic               jump,
  input  logic [ADDR_W-1:0]  next_pc,
  output logic [1:0]         pc_sel,
  output logic [ADDR_W-1:0]  pc_inc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
`ifdef FETCH_PERF_EN
  output logic [15:0]        stall_count,
`endif
  input  logic               instr_ready
);

  fetch_state_e      state_r;
  fetch_state_e      state_nxt_s;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] req_addr_r;
  logic              valid_q_r;
  logic              redirect_s;
  logic              req_s;
  logic              capture_s;
  logic              park_s;
  logic              transfer_s;
  logic              pc_load_s;

  assign pc_inc = pc_r + ADDR_W'(1);

  // Redirect decode and next-PC mux select; stays live while in reset.
  always_comb begin
    redirect_s = jump | branch_taken;
    if (jump) begin
      pc_sel = PC_SEL_JMP;
    end else if (branch_taken) begin
      pc_sel = PC_SEL_BR;
    end else begin
      pc_sel = PC_SEL_INC;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      FETCH: begin
        if (imem_ack && !redirect_s) begin
          state_nxt_s = WAIT_DEC;
        end else if (!imem_ack && redirect_s) begin
          state_nxt_s = DISCARD;
        end else begin
          state_nxt_s = FETCH;
        end
      end
      DISCARD: begin
        if (imem_ack) begin
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = DISCARD;
        end
      end
      WAIT_DEC: begin
        if (redirect_s || instr_ready) begin
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = WAIT_DEC;
        end
      end
      default: state_nxt_s = FETCH;
    endcase
  end

  // FSM outputs; a pending request keeps its old address in DISCARD so it is stable until ack.
  always_comb begin
    req_s       = 1'b0;
    imem_addr   = pc_r;
    instr_valid = 1'b0;
    capture_s   = 1'b0;
    park_s      = 1'b0;
    case (state_r)
      FETCH: begin
        req_s     = 1'b1;
        imem_addr = pc_r;
        capture_s = imem_ack & ~redirect_s;
        park_s    = ~imem_ack & redirect_s;
      end
      DISCARD: begin
        req_s     = 1'b1;
        imem_addr = req_addr_r;
      end
      WAIT_DEC: begin
        instr_valid = valid_q_r & ~redirect_s;
      end
      default: begin
        req_s = 1'b0;
      end
    endcase
    imem_req   = req_s & rst_n;
    transfer_s = instr_valid & instr_ready;
    pc_load_s  = redirect_s | transfer_s;
  end

  // PC, parked request address and captured instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r       <= RESET_PC;
      req_addr_r <= RESET_PC;
      instr      <= {INSTR_W{1'b0}};
      instr_pc   <= {ADDR_W{1'b0}};
      valid_q_r  <= 1'b0;
    end else begin
      if (pc_load_s) begin
        pc_r <= next_pc;
      end
      if (park_s) begin
        req_addr_r <= pc_r;
      end
      if (capture_s) begin
        instr    <= imem_data;
        instr_pc <= pc_r;
      end
      valid_q_r <= (state_nxt_s == WAIT_DEC);
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating count of cycles where decode holds off a valid instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= 16'h0000;
    end else if (valid_q_r && !instr_ready && !redirect_s && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// checked against a transaction-level model of the fetch stage.
module tb_fetch_unit;

  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        branch_taken = 1'b0;
  logic        jump = 1'b0;
  logic [15:0] next_pc = 16'h0000;
  logic [1:0]  pc_sel;
  logic [15:0] pc_inc;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
`ifdef FETCH_PERF_EN
  logic [15:0] stall_count;
`endif

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(16), .INSTR_W(16), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .branch_taken(branch_taken), .jump(jump),
    .next_pc(next_pc), .pc_sel(pc_sel), .pc_inc(pc_inc), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
`ifdef FETCH_PERF_EN
    .stall_count(stall_count),
`endif
    .instr_ready(instr_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: a held instruction awaiting decode, or an orphaned request whose data is junk.
  logic [15:0] m_pc, m_stale_addr, m_instr, m_instr_pc, m_cnt;
  bit          m_has, m_stale;
  logic [15:0] exp_addr, exp_inc;
  logic [1:0]  exp_sel;
  bit          exp_req, exp_valid;

  task automatic model_reset();
    m_pc = RST_PC; m_stale_addr = RST_PC; m_instr = 16'h0000; m_instr_pc = 16'h0000;
    m_cnt = 16'h0000; m_has = 1'b0; m_stale = 1'b0;
  endtask

  // Drive one cycle of inputs; the bench plays the external next-PC mux and the memory.
  task automatic drive(input bit j, input bit b, input bit rdy, input bit ack,
                       input logic [15:0] data, input logic [15:0] jt, input logic [15:0] bt);
    jump = j; branch_taken = b; instr_ready = rdy; imem_data = data;
    imem_ack  = ack & ~m_has;
    exp_sel   = j ? 2'b10 : (b ? 2'b01 : 2'b00);
    exp_inc   = m_pc + 16'd1;
    next_pc   = j ? jt : (b ? bt : exp_inc);
    exp_req   = ~m_has;
    exp_addr  = m_stale ? m_stale_addr : m_pc;
    exp_valid = m_has & ~(j | b);
    #1;
  endtask

  task automatic tick();
    bit r, xfer;
    @(posedge clk);
    r    = jump | branch_taken;
    xfer = m_has & ~r & instr_ready;
    if (m_has && !instr_ready && !r && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    if (m_has) begin
      if (r || instr_ready) m_has = 1'b0;
    end else if (m_stale) begin
      if (imem_ack) m_stale = 1'b0;
    end else if (imem_ack && !r) begin
      m_has = 1'b1; m_instr = imem_data; m_instr_pc = m_pc;
    end else if (!imem_ack && r) begin
      m_stale = 1'b1; m_stale_addr = m_pc;
    end
    if (r || xfer) m_pc = next_pc;
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    n_checks++; if (instr !== 16'h0000) begin n_fail++; $display("FAIL rst_instr: got %h want 0000", instr); end
    n_checks++; if (instr_pc !== 16'h0000) begin n_fail++; $display("FAIL rst_instr_pc: got %h want 0000", instr_pc); end
    n_checks++; if (pc_inc !== 16'h0001) begin n_fail++; $display("FAIL rst_pc_inc: got %h want 0001", pc_inc); end
    n_checks++; if (pc_sel !== 2'b00) begin n_fail++; $display("FAIL rst_pc_sel: got %b want 00", pc_sel); end
    jump = 1'b1; #1;
    n_checks++; if (pc_sel !== 2'b10) begin n_fail++; $display("FAIL rst_pc_sel_jmp: got %b want 10", pc_sel); end
    jump = 1'b0;
`ifdef FETCH_PERF_EN
    n_checks++; if (stall_count !== 16'h0000) begin n_fail++; $display("FAIL rst_stall: got %h want 0000", stall_count); end
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h1000 + 16'(k), 16'h0, 16'h0);
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'(k)) begin n_fail++; $display("FAIL seq_addr: got req=%b addr=%h want 1/%h", imem_req, imem_addr, 16'(k)); end
      n_checks++; if (pc_sel !== 2'b00) begin n_fail++; $display("FAIL seq_pc_sel: got %b want 00", pc_sel); end
      tick();
      drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
      n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'(k) || instr !== 16'h1000 + 16'(k)) begin n_fail++; $display("FAIL seq_instr: got v=%b pc=%h i=%h want 1/%h/%h", instr_valid, instr_pc, instr, 16'(k), 16'h1000 + 16'(k)); end
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL seq_req_low: got %b want 0", imem_req); end
      tick();
    end
  endtask

  task automatic test_decode_stall();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 16'hBEEF, 16'h0, 16'h0);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
      n_checks++; if (instr_valid !== 1'b1 || instr !== 16'hBEEF || instr_pc !== 16'h0003) begin n_fail++; $display("FAIL stall_hold: got v=%b i=%h pc=%h want 1/beef/0003", instr_valid, instr, instr_pc); end
      n_checks++; if (imem_req !== 1'b0 || pc_inc !== 16'h0004) begin n_fail++; $display("FAIL stall_pc: got req=%b inc=%h want 0/0004", imem_req, pc_inc); end
      tick();
    end
`ifdef FETCH_PERF_EN
    n_checks++; if (stall_count !== 16'd5) begin n_fail++; $display("FAIL stall_count: got %0d want 5", stall_count); end
`endif
  endtask

  task automatic test_branch_wait_dec();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0040);
    n_checks++; if (pc_sel !== 2'b01 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL br_squash: got sel=%b v=%b want 01/0", pc_sel, instr_valid); end
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin n_fail++; $display("FAIL br_addr: got req=%b addr=%h want 1/0040", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_pending();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0005, 16'h0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 16'h0, 16'h0);
    n_checks++; if (imem_addr !== 16'h0040) begin n_fail++; $display("FAIL pend_old_addr: got %h want 0040", imem_addr); end
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0100, 16'h0);
    n_checks++; if (pc_sel !== 2'b10 || imem_addr !== 16'h0005) begin n_fail++; $display("FAIL pend_jump: got sel=%b addr=%h want 10/0005", pc_sel, imem_addr); end
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0005) begin n_fail++; $display("FAIL pend_stable: got req=%b addr=%h want 1/0005", imem_req, imem_addr); end
      tick();
    end
    drive(1'b0, 1'b0, 1'b1, 1'b1, 16'hDEAD, 16'h0, 16'h0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
    n_checks++; if (instr_valid !== 1'b0 || instr !== 16'hBEEF) begin n_fail++; $display("FAIL pend_drop: got v=%b i=%h want 0/beef", instr_valid, instr); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin n_fail++; $display("FAIL pend_new_addr: got req=%b addr=%h want 1/0100", imem_req, imem_addr); end
  endtask

  task automatic test_same_cycle_ack_jump();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 16'hCAFE, 16'h0200, 16'h0300);
    n_checks++; if (pc_sel !== 2'b10 || imem_addr !== 16'h0100) begin n_fail++; $display("FAIL ackjmp_sel: got sel=%b addr=%h want 10/0100", pc_sel, imem_addr); end
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
    n_checks++; if (instr_valid !== 1'b0 || instr !== 16'hBEEF) begin n_fail++; $display("FAIL ackjmp_drop: got v=%b i=%h want 0/beef", instr_valid, instr); end
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0200) begin n_fail++; $display("FAIL ackjmp_addr: got req=%b addr=%h want 1/0200", imem_req, imem_addr); end
  endtask

  task automatic test_wrap();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 16'hFFFF, 16'h0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 16'h0, 16'h0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 16'h7777, 16'h0, 16'h0);
    n_checks++; if (imem_addr !== 16'hFFFF || pc_inc !== 16'h0000) begin n_fail++; $display("FAIL wrap_inc: got addr=%h inc=%h want ffff/0000", imem_addr, pc_inc); end
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 16'hFFFF || instr !== 16'h7777) begin n_fail++; $display("FAIL wrap_instr: got v=%b pc=%h i=%h want 1/ffff/7777", instr_valid, instr_pc, instr); end
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin n_fail++; $display("FAIL wrap_addr: got req=%b addr=%h want 1/0000", imem_req, imem_addr); end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 16'h1234, 16'h0);
    tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
    rst_n = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL arst_req: got req=%b v=%b want 0/0", imem_req, instr_valid); end
    n_checks++; if (instr !== 16'h0000 || instr_pc !== 16'h0000) begin n_fail++; $display("FAIL arst_instr: got i=%h pc=%h want 0000/0000", instr, instr_pc); end
    n_checks++; if (pc_inc !== 16'h0001) begin n_fail++; $display("FAIL arst_pc: got inc=%h want 0001", pc_inc); end
    jump = 1'b0; branch_taken = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin n_fail++; $display("FAIL arst_restart: got req=%b addr=%h want 1/%h", imem_req, imem_addr, RST_PC); end
  endtask

  task automatic test_random();
    bit j, b, rdy, ack;
    for (int i = 0; i < 800; i++) begin
      j   = ($urandom_range(7) == 0);
      b   = ($urandom_range(5) == 0);
      rdy = ($urandom_range(9) < 6);
      ack = ($urandom_range(1) == 1);
      drive(j, b, rdy, ack, 16'($urandom), 16'($urandom), 16'($urandom));
      n_checks++; if (pc_sel !== exp_sel || pc_inc !== exp_inc) begin n_fail++; $display("FAIL rnd_sel[%0d]: got sel=%b inc=%h want %b/%h", i, pc_sel, pc_inc, exp_sel, exp_inc); end
      n_checks++; if (imem_req !== exp_req) begin n_fail++; $display("FAIL rnd_req[%0d]: got %b want %b", i, imem_req, exp_req); end
      if (exp_req) begin
        n_checks++; if (imem_addr !== exp_addr) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, imem_addr, exp_addr); end
      end
      n_checks++; if (instr_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, instr_valid, exp_valid); end
      n_checks++; if (instr !== m_instr || instr_pc !== m_instr_pc) begin n_fail++; $display("FAIL rnd_instr[%0d]: got %h@%h want %h@%h", i, instr, instr_pc, m_instr, m_instr_pc); end
`ifdef FETCH_PERF_EN
      n_checks++; if (stall_count !== m_cnt) begin n_fail++; $display("FAIL rnd_stall[%0d]: got %0d want %0d", i, stall_count, m_cnt); end
`endif
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_decode_stall();
    test_branch_wait_dec();
    test_redirect_pending();
    test_same_cycle_ack_jump();
    test_wrap();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
